// File: rtl/online_softmax_accum_pkg.sv
// Shared types and constants for the online softmax accumulator.
package online_softmax_accum_pkg;

  localparam int unsigned DK          = 64;
  localparam int unsigned INT_WIDTH   = 8;
  localparam int unsigned EXP_FRAC    = 8;
  localparam int unsigned O_WIDTH     = 32;
  localparam int unsigned L_WIDTH     = 24;
  // Score differences carry one extra bit so s - m never wraps.
  localparam int unsigned DIFF_WIDTH  = INT_WIDTH + 1;
  // Reciprocal floor(2^L_WIDTH / l) needs one bit more than l.
  localparam int unsigned RECIP_WIDTH = L_WIDTH + 1;

  typedef logic signed [INT_WIDTH-1:0]    INT_T;
  typedef logic [DK-1:0][INT_WIDTH-1:0]   V_VECTOR_T;
  typedef logic signed [O_WIDTH-1:0]      O_ELEM_T;
  typedef logic [DK-1:0][O_WIDTH-1:0]     O_VECTOR_T;
  typedef logic [L_WIDTH-1:0]             L_T;

  localparam L_T EXP_ONE = L_T'(1) << EXP_FRAC;

  typedef enum logic [1:0] {
    StAccum,
    StEmit,
    StRecip
  } state_e;

  // Sign-extend a score/V element to accumulator width.
  function automatic O_ELEM_T sext_int(input INT_T x);
    return {{(O_WIDTH - INT_WIDTH){x[INT_WIDTH-1]}}, x};
  endfunction

endpackage

// File: rtl/online_softmax_accum_recip_divider.sv
// Sequential restoring divider computing floor(2^L_WIDTH / divisor), one quotient
// bit per cycle over RECIP_WIDTH cycles. Used only when AURA_SOFTMAX_NORM_EN is set.
module recip_divider
  import online_softmax_accum_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  L_T                     divisor,
  output logic                   busy,
  output logic                   done,
  output logic [RECIP_WIDTH-1:0] quotient
);

  localparam int unsigned CntW = $clog2(RECIP_WIDTH + 1);

  L_T                     rem_q;
  L_T                     dvs_q;
  logic [RECIP_WIDTH-1:0] quo_q;
  logic [CntW-1:0]        cnt_q;
  logic [RECIP_WIDTH-1:0] trial;
  logic                   fits;
  L_T                     rem_d;

  assign quotient = quo_q;

  // One restoring step: shift in the next dividend bit and subtract if it fits
  always_comb begin
    trial = {rem_q, quo_q[RECIP_WIDTH-1]};
    fits  = (trial >= {1'b0, dvs_q});
    rem_d = fits ? L_T'(trial - {1'b0, dvs_q}) : trial[L_WIDTH-1:0];
  end

  // Iteration control; quo_q holds pending dividend bits above finished quotient bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= '0;
        dvs_q <= divisor;
        quo_q <= RECIP_WIDTH'(1) << L_WIDTH;
        cnt_q <= CntW'(RECIP_WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_d;
        quo_q <= {quo_q[RECIP_WIDTH-2:0], fits};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/online_softmax_accum.sv
// FlashAttention-style online softmax over one query row: tracks running max m,
// denominator l and weighted V accumulator o; emits the row on the last key.
// Optional feature macro: AURA_SOFTMAX_NORM_EN (normalize o by 1/l before emit).
module online_softmax_accum
  import online_softmax_accum_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      vld_in,
  output logic      rdy_out,
  input  INT_T      s_in,
  input  V_VECTOR_T v_in,
  input  logic      last_in,
  output logic      vld_out,
  input  logic      rdy_in,
  output O_VECTOR_T o_out,
  output L_T        l_out,
  output INT_T      m_out
);

  localparam int unsigned ShiftW  = $clog2(O_WIDTH);
  localparam int unsigned PShiftW = $clog2(EXP_FRAC + 1);

  state_e    state_q;
  logic      first_q;
  O_VECTOR_T o_q, o_d;
  L_T        l_q, l_d;
  INT_T      m_q, m_d;
  logic      accept;

  logic signed [DIFF_WIDTH-1:0] diff;
  logic [DIFF_WIDTH-1:0]        mag;
  logic                         new_max;
  logic                         in_range;
  logic [ShiftW-1:0]            dc;
  logic [PShiftW-1:0]           p_shift;
  L_T                           p_l;
  O_ELEM_T                      vx, vone, oq;

  assign rdy_out = (state_q == StAccum);
  assign accept  = vld_in && rdy_out;

  // Compare the incoming score with the running max and derive shift amounts
  always_comb begin
    diff     = {s_in[INT_WIDTH-1], s_in} - {m_q[INT_WIDTH-1], m_q};
    new_max  = !diff[DIFF_WIDTH-1] && (diff != '0);
    mag      = new_max ? diff : -diff;
    in_range = (mag <= DIFF_WIDTH'(EXP_FRAC));
    dc       = (mag > DIFF_WIDTH'(O_WIDTH - 1)) ? ShiftW'(O_WIDTH - 1) : mag[ShiftW-1:0];
    // v * (ONE >> d) is exact as v << (EXP_FRAC - d) for d <= EXP_FRAC
    p_shift  = in_range ? PShiftW'(EXP_FRAC) - mag[PShiftW-1:0] : '0;
    p_l      = in_range ? (EXP_ONE >> mag) : '0;
  end

  // Next accumulator, denominator and max for the key on the input
  always_comb begin
    o_d  = o_q;
    l_d  = l_q;
    m_d  = m_q;
    vx   = '0;
    vone = '0;
    oq   = '0;
    for (int i = 0; i < DK; i++) begin
      vx   = sext_int(INT_T'(v_in[i]));
      vone = vx <<< EXP_FRAC;
      oq   = O_ELEM_T'(o_q[i]);
      if (first_q) begin
        o_d[i] = vone;
      end else if (new_max) begin
        o_d[i] = (oq >>> dc) + vone;
      end else if (in_range) begin
        o_d[i] = oq + (vx <<< p_shift);
      end
    end
    if (first_q) begin
      l_d = EXP_ONE;
      m_d = s_in;
    end else if (new_max) begin
      l_d = (l_q >> dc) + EXP_ONE;
      m_d = s_in;
    end else begin
      l_d = l_q + p_l;
    end
  end

`ifdef AURA_SOFTMAX_NORM_EN
  localparam int unsigned NormShift = L_WIDTH - EXP_FRAC;

  logic                                 div_start;
  logic                                 div_busy;
  logic                                 div_done;
  logic [RECIP_WIDTH-1:0]               div_q;
  O_VECTOR_T                            o_norm;
  logic signed [O_WIDTH+RECIP_WIDTH:0]  prod;

  // Divider latches the final l on the same edge that accepts the last key
  assign div_start = accept && last_in;

  recip_divider u_recip_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .divisor  (l_d),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // Scale each accumulator by the reciprocal back into Q.EXP_FRAC
  always_comb begin
    o_norm = '0;
    prod   = '0;
    for (int i = 0; i < DK; i++) begin
      prod      = $signed(o_q[i]) * $signed({1'b0, div_q});
      o_norm[i] = prod[NormShift +: O_WIDTH];
    end
  end
`endif

  // Row FSM with accumulator state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
      first_q <= 1'b1;
      o_q     <= '0;
      l_q     <= '0;
      m_q     <= '0;
      vld_out <= 1'b0;
      o_out   <= '0;
      l_out   <= '0;
      m_out   <= '0;
    end else begin
      case (state_q)
        StAccum: begin
          if (accept) begin
            o_q     <= o_d;
            l_q     <= l_d;
            m_q     <= m_d;
            first_q <= last_in;
            if (last_in) begin
              l_out <= l_d;
              m_out <= m_d;
`ifdef AURA_SOFTMAX_NORM_EN
              state_q <= StRecip;
`else
              o_out   <= o_d;
              vld_out <= 1'b1;
              state_q <= StEmit;
`endif
            end
          end
        end
`ifdef AURA_SOFTMAX_NORM_EN
        StRecip: begin
          if (div_done && !div_busy) begin
            o_out   <= o_norm;
            vld_out <= 1'b1;
            state_q <= StEmit;
          end
        end
`endif
        StEmit: begin
          if (rdy_in) begin
            vld_out <= 1'b0;
            state_q <= StAccum;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule

// File: tb/tb_online_softmax_accum.sv
// Randomized self-checking bench for online_softmax_accum against a plain
// arithmetic model of the online softmax rules. Honors AURA_SOFTMAX_NORM_EN.
module tb_online_softmax_accum;
  import online_softmax_accum_pkg::*;

`ifdef AURA_SOFTMAX_NORM_EN
  localparam int Lat = 1 + RECIP_WIDTH;
`else
  localparam int Lat = 1;
`endif

  typedef int vrow_t [DK];

  logic      clk = 1'b0;
  logic      rst;
  logic      vld_in;
  logic      rdy_out;
  INT_T      s_in;
  V_VECTOR_T v_in;
  logic      last_in;
  logic      vld_out;
  logic      rdy_in;
  O_VECTOR_T o_out;
  L_T        l_out;
  INT_T      m_out;

  int     ks[$];
  vrow_t  kv[$];
  longint exp_o [DK];
  longint exp_l;
  longint exp_m;
  int     total = 0;
  int     bad   = 0;

  online_softmax_accum dut (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_in),
    .rdy_out (rdy_out),
    .s_in    (s_in),
    .v_in    (v_in),
    .last_in (last_in),
    .vld_out (vld_out),
    .rdy_in  (rdy_in),
    .o_out   (o_out),
    .l_out   (l_out),
    .m_out   (m_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint o_at(input int i);
    return longint'($signed(o_out[i]));
  endfunction

  // Softmax rules applied key by key with ordinary integer arithmetic
  function automatic void compute_expected();
    longint m, l, p, r;
    int d, dc;
    m = ks[0];
    l = 256;
    for (int i = 0; i < DK; i++) exp_o[i] = longint'(kv[0][i]) * 256;
    for (int k = 1; k < ks.size(); k++) begin
      if (ks[k] > m) begin
        d  = ks[k] - int'(m);
        dc = (d > 31) ? 31 : d;
        for (int i = 0; i < DK; i++) exp_o[i] = (exp_o[i] >>> dc) + longint'(kv[k][i]) * 256;
        l = (l >> dc) + 256;
        m = ks[k];
      end else begin
        d = int'(m) - ks[k];
        p = (d <= 8) ? (256 >> d) : 0;
        for (int i = 0; i < DK; i++) exp_o[i] = exp_o[i] + longint'(kv[k][i]) * p;
        l = l + p;
      end
    end
`ifdef AURA_SOFTMAX_NORM_EN
    r = (longint'(1) << 24) / l;
    for (int i = 0; i < DK; i++) exp_o[i] = (exp_o[i] * r) >>> 16;
`else
    r = 0;
`endif
    exp_l = l;
    exp_m = m;
  endfunction

  function automatic void push_uniform(input int s, input int v);
    vrow_t row;
    for (int i = 0; i < DK; i++) row[i] = v;
    ks.push_back(s);
    kv.push_back(row);
  endfunction

  function automatic void push_random(input int s_lo, input int s_hi);
    vrow_t row;
    for (int i = 0; i < DK; i++) row[i] = int'($urandom_range(0, 255)) - 128;
    ks.push_back(int'($urandom_range(0, s_hi - s_lo)) + s_lo);
    kv.push_back(row);
  endfunction

  task automatic send_key(input int s, input int k, input bit last);
    int waited = 0;
    s_in    = INT_T'(s);
    for (int i = 0; i < DK; i++) v_in[i] = INT_WIDTH'(kv[k][i]);
    last_in = last;
    vld_in  = 1'b1;
    while (!rdy_out && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy_out) check_eq("rdy_timeout", 0, 1);
    @(posedge clk);
    #1;
    vld_in  = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic run_row(input int hold);
    int n = ks.size();
    int cyc = 0;
    compute_expected();
    for (int k = 0; k < n; k++) send_key(ks[k], k, k == n - 1);
    do begin
      @(negedge clk);
      cyc++;
    end while (!vld_out && cyc < 60);
    check_eq("latency", cyc, Lat);
    check_eq("vld_out", longint'(vld_out), 1);
    check_eq("l_out", longint'(l_out), exp_l);
    check_eq("m_out", longint'($signed(m_out)), exp_m);
    for (int i = 0; i < DK; i++) check_eq($sformatf("o_out[%0d]", i), o_at(i), exp_o[i]);
    for (int h = 0; h < hold; h++) begin
      vld_in = 1'b1;
      s_in   = INT_T'($urandom_range(0, 255));
      @(negedge clk);
      check_eq("hold_rdy_out", longint'(rdy_out), 0);
      check_eq("hold_vld_out", longint'(vld_out), 1);
      check_eq("hold_l_out", longint'(l_out), exp_l);
      check_eq("hold_o_out0", o_at(0), exp_o[0]);
    end
    vld_in = 1'b0;
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    rdy_in = 1'b0;
    @(negedge clk);
    check_eq("drop_vld_out", longint'(vld_out), 0);
    check_eq("rearm_rdy_out", longint'(rdy_out), 1);
    ks.delete();
    kv.delete();
  endtask

  initial begin
    rst     = 1'b1;
    vld_in  = 1'b0;
    s_in    = '0;
    v_in    = '0;
    last_in = 1'b0;
    rdy_in  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_vld_out", longint'(vld_out), 0);
    check_eq("rst_l_out", longint'(l_out), 0);
    check_eq("rst_m_out", longint'(m_out), 0);
    check_eq("rst_o_out0", o_at(0), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rdy_out", longint'(rdy_out), 1);

    // Directed rows
    push_uniform(5, 3);                           run_row(0);
    push_uniform(2, 1);   push_uniform(2, 2);     run_row(5);
    push_uniform(0, 4);   push_uniform(1, 2);     run_row(0);
    push_uniform(10, 1);  push_uniform(0, 100);   run_row(0);
    push_uniform(0, -3);  push_uniform(2, 0);     run_row(0);
    push_uniform(-128, 7); push_uniform(127, -5); push_uniform(-128, 9); run_row(0);

    // Random rows, mostly near-equal scores with occasional wide spreads
    for (int r = 0; r < 24; r++) begin
      int n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        if ((r % 4) == 3) push_random(-128, 127);
        else push_random(-6, 6);
      end
      run_row((r % 5) == 0 ? 2 : 0);
    end

    // Reset mid-row discards the partial row and clears every output
    for (int k = 0; k < 3; k++) push_random(-4, 4);
    for (int k = 0; k < 3; k++) send_key(ks[k], k, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_vld_out", longint'(vld_out), 0);
    check_eq("midrst_l_out", longint'(l_out), 0);
    check_eq("midrst_m_out", longint'(m_out), 0);
    check_eq("midrst_o_out5", o_at(5), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_rdy_out", longint'(rdy_out), 1);
    ks.delete();
    kv.delete();
    push_random(-7, -7);
    run_row(0);
    push_uniform(3, 2);   push_uniform(1, -4);    run_row(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/online_softmax_accum.md
# online_softmax_accum

Consumes the scaled score stream (one `s`/`v` pair per key) from `dot_product` and applies FlashAttention-style online softmax over one query row. It tracks the running max `m` and running denominator `l`, and accumulates the weighted V vector `o`. On the key flagged last it emits the row result to the output writer, then rearms for the next row. Exponentials are base-2 and shift-only; scores are already in log2 units.

## Interface
- `DK`, 64, vector length (elements of V/O)
- `INT_WIDTH`, 8, signed width of score and V elements
- `EXP_FRAC`, 8, fraction bits of softmax weight; ONE = 2^EXP_FRAC
- `O_WIDTH`, 32, signed accumulator width per O element
- `L_WIDTH`, 24, unsigned denominator width
- `clk` in 1 — clock
- `rst` in 1 — asynchronous, active-high reset
- `vld_in` in 1 — upstream `s_in`/`v_in`/`last_in` valid
- `rdy_out` out 1 — block can accept an input
- `s_in` in INT_WIDTH — signed score for this key
- `v_in` in DK×INT_WIDTH — signed V vector for this key
- `last_in` in 1 — final key of the current row
- `vld_out` out 1 — row result valid
- `rdy_in` in 1 — downstream ready
- `o_out` out DK×O_WIDTH — row accumulator (see Configuration)
- `l_out` out L_WIDTH — row denominator
- `m_out` out INT_WIDTH — row max score

## Operation
- **States:** ACCUM, EMIT (plus RECIP with the macro). Reset state is ACCUM, with internal `first`=1.
- **Acceptance:** `rdy_out` = (state==ACCUM). An input is accepted when `vld_in && rdy_out`.
- **First key of row** (`first`=1): m=s; l=ONE; o[i]=v[i]·ONE; `first` clears.
- **New maximum** (s>m): d=s−m; o[i]=(o[i]>>>dc)+v[i]·ONE; l=(l>>dc)+ONE; m=s.
  - dc = min(d, O_WIDTH−1).
  - The arithmetic shift leaves negatives at −1 at most; no rounding is applied.
- **Otherwise** (s≤m): d=m−s; p = ONE>>d if d≤EXP_FRAC, else 0; o[i]+=v[i]·p; l+=p. When s==m, p=ONE.
- **All arithmetic** is signed, sign-extended to O_WIDTH. Differences are computed at INT_WIDTH+1 bits, so there is no wrap.
- **Row length:** ≤4096 keys. l and o overflow is unchecked beyond that and wraps modulo width.
- **Accepted `last_in`:** the same update applies. Results are copied into the output registers, state goes to EMIT (or RECIP), and `first` sets.
- **EMIT:** `vld_out`=1 and outputs are held stable until `rdy_in`. On the `vld_out && rdy_in` cycle, the next state is ACCUM and `vld_out` drops on the following edge.
- **Reset:** at any time it discards the partial row. Every output register is 0: `vld_out`=0, `o_out`/`l_out`/`m_out`=0. `rdy_out`=1 after release.

## Timing
- **Update latency:** an input accepted on edge t updates internal state at t+1. Back-to-back acceptance runs at 1 key per cycle.
- **Result latency:** `last_in` accepted at edge t gives `vld_out`=1 from t+1. With the macro, `vld_out`=1 from t+1+(L_WIDTH+1).
- **Row turnaround:** minimum one bubble per row (`rdy_out`=0 during EMIT).
- **Outputs:** all registered; no combinational path from `vld_in` or `rdy_in` to any output except via state.

## Configuration
- **`AURA_SOFTMAX_NORM_EN` defined:**
  - After `last_in`, the RECIP state computes r=floor(2^24/l) by restoring division, one bit per cycle, L_WIDTH+1 cycles.
  - It then enters EMIT with o_out[i]=(o[i]·r)>>>16, i.e. the normalized value in Q.EXP_FRAC.
  - `l_out` and `m_out` are unchanged.
- **Undefined:** no RECIP state. `o_out` is the raw accumulator; normalization happens downstream.

## Structure
- **Shared package:** add `O_ELEM_T` (O_WIDTH signed), `O_VECTOR_T` (DK×`O_ELEM_T`), `L_T`, and the constant `EXP_ONE`.
- **Reused from the package:** `INT_T`, `V_VECTOR_T`, `DK`.
- **Sub-module:** `recip_divider` (sequential restoring divider: start/busy/done), instantiated only under `AURA_SOFTMAX_NORM_EN`.

## Test plan
- **Single-key row:** s=5, v[i]=3, last → next cycle `vld_out`=1, o[i]=768, l=256, m=5.
- **Equal scores:** s=2 v=1; s=2 v=2 last → o[i]=768, l=512, m=2.
- **Rising max:** s=0 v=4; s=1 v=2 last → o[i]=1024, l=384, m=1.
- **Falling max with negative v:**
  - s=10 v=1; s=0 v=100 last → o=256, l=256 (p=0).
  - s=0 v=−3; s=2 v=0 last → o=−192, l=320.
- **Backpressure and reset:**
  - Hold `rdy_in`=0 for 5 cycles in EMIT → outputs stable, `rdy_out`=0, no acceptance.
  - Assert `rst` after 3 keys → all outputs 0; next row starts fresh (first-key rule).
- **Macro build:** s=0 v=3 last → `vld_out` 26 cycles after acceptance, o[i]=768, l=256.
